// File: rtl/mem_rsp_pkg.sv
// Shared types and defaults for the multi-cycle memory responder.
package mem_rsp_pkg;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  localparam int unsigned DEFAULT_DEPTH_WORDS = 256;
  localparam int unsigned DEFAULT_WAIT_STATES = 2;
  localparam int unsigned BYTE_LANES          = 4;

  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word RAM with per-byte write enables and a registered read port.
module mem_array
  import mem_rsp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int unsigned IDX_W       = idx_width(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [BYTE_LANES-1:0] be,
  input  logic [IDX_W-1:0]      idx,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < BYTE_LANES; i++) begin
          if (be[i]) begin
            mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end else begin
        rdata_q <= mem_q[idx];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/multi_cycle_mem_responder.sv
// Unified fetch/load/store memory responder with programmable wait states.
// Define MEM_ERR_EN to flag misaligned and out-of-range accesses via rsp_err.
module multi_cycle_mem_responder
  import mem_rsp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int unsigned WAIT_STATES = DEFAULT_WAIT_STATES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [BYTE_LANES-1:0] req_be,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int unsigned IdxW    = idx_width(DEPTH_WORDS);
  localparam logic [3:0]  CntInit = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  we_q, err_q;
  logic [31:0]           addr_q, wdata_q;
  logic [BYTE_LANES-1:0] be_q;
  logic                  access, fault;
  logic                  acc_we;
  logic [31:0]           acc_addr, acc_wdata;
  logic [BYTE_LANES-1:0] acc_be;
  logic [31:0]           ram_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (WAIT_STATES == 0) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = CntInit;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) state_d = StResp;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    access    = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        access    = req_valid && (WAIT_STATES == 0);
      end
      StWait:  access    = (cnt_q == 4'd0);
      StResp:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign busy = !req_ready;

  // With zero wait states the access happens in the accept cycle, before the latches load.
  always_comb begin
    if (state_q == StIdle) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end else begin
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_be    = be_q;
    end
  end

`ifdef MEM_ERR_EN
  assign fault = (acc_addr[1:0] != 2'b00) || (acc_addr[31:IdxW+2] != '0);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{acc_addr[31:IdxW+2], acc_addr[1:0]};
  assign fault            = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      if (req_ready && req_valid) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        be_q    <= req_be;
      end
      if (access) err_q <= fault;
    end
  end

  // Reset wins over an access edge, so an abandoned write never reaches the array.
  mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IdxW)
  ) u_mem_array (
    .clk  (clk),
    .en   (access && !rst),
    .we   (acc_we && !fault),
    .be   (acc_be),
    .idx  (acc_addr[IdxW+1:2]),
    .wdata(acc_wdata),
    .rdata(ram_rdata)
  );

  assign rsp_rdata = (rsp_valid && !we_q && !err_q) ? ram_rdata : 32'd0;
  assign rsp_err   = rsp_valid && err_q;

endmodule

// File: tb/tb_multi_cycle_mem_responder.sv
// Directed self-checking bench: WAIT_STATES=2 instance plus a WAIT_STATES=0 instance.
module tb_multi_cycle_mem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_be;

  logic        z_req_valid, z_req_ready, z_req_we, z_rsp_valid, z_rsp_ready, z_rsp_err, z_busy;
  logic [31:0] z_req_addr, z_req_wdata, z_rsp_rdata;
  logic [3:0]  z_req_be;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic [31:0] rd;
  logic        er;
  int          lat;

  multi_cycle_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
  );

  multi_cycle_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata),
    .rsp_err(z_rsp_err), .busy(z_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Accept one request on dut; returns at the negedge of the first RESP cycle.
  task automatic start_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, output int l);
    req_we = we; req_addr = addr; req_wdata = wdata; req_be = be; req_valid = 1'b1;
    @(negedge clk);
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1 req_valid = 1'b0;
    l = 0;
    while (l < 20) begin
      @(negedge clk);
      l++;
      if (rsp_valid) break;
    end
  endtask

  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, output logic [31:0] rdata, output logic err);
    int l;
    start_req(we, addr, wdata, be, l);
    chk("latency_ws2", l, 32'd3);
    rdata = rsp_rdata;
    err   = rsp_err;
    @(posedge clk); #1;
  endtask

  task automatic zwrite(input logic [31:0] addr, input logic [31:0] wdata);
    z_req_we = 1'b1; z_req_addr = addr; z_req_wdata = wdata; z_req_be = 4'hF; z_req_valid = 1'b1;
    @(posedge clk); #1 z_req_valid = 1'b0; z_req_we = 1'b0;
    @(negedge clk);
    chk("z_wr_rsp_valid", {31'd0, z_rsp_valid}, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    rsp_ready = 1'b1;
    z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_req_be = '0;
    z_rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
    chk("rst_busy",      {31'd0, busy},      32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Full store then load back
    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er);
    chk("st_full_rdata", rd, 32'd0);
    chk("st_full_err", {31'd0, er}, 32'd0);
    txn(1'b0, 32'h10, 32'd0, 4'h0, rd, er);
    chk("ld_full", rd, 32'hDEADBEEF);

    // Partial store, lanes 0 and 2
    txn(1'b1, 32'h10, 32'h11223344, 4'b0101, rd, er);
    txn(1'b0, 32'h10, 32'd0, 4'h0, rd, er);
    chk("ld_partial", rd, 32'hDE22BE44);

    // Response stall with a pending request held on the input
    rsp_ready = 1'b0;
    start_req(1'b0, 32'h10, 32'd0, 4'h0, lat);
    chk("stall_latency", lat, 32'd3);
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D; req_be = 4'hF; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("stall_rsp_rdata", rsp_rdata, 32'hDE22BE44);
      chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_hs_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("post_hs_req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1 req_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
    end
    chk("second_req_latency", lat, 32'd3);
    chk("second_req_rdata", rsp_rdata, 32'd0);
    @(posedge clk); #1;
    txn(1'b0, 32'h20, 32'd0, 4'h0, rd, er);
    chk("ld_after_stall_wr", rd, 32'hCAFEF00D);

    // Reset on the access edge of a store: the write must be abandoned
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_be = 4'hF; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    chk("wait_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    txn(1'b0, 32'h20, 32'd0, 4'h0, rd, er);
    chk("ld_after_rst_abandon", rd, 32'hCAFEF00D);

    // Fault / wrap behaviour
    txn(1'b1, 32'h0, 32'hA5A5A5A5, 4'hF, rd, er);
`ifdef MEM_ERR_EN
    txn(1'b1, 32'h12, 32'hFFFFFFFF, 4'hF, rd, er);
    chk("misalign_st_err", {31'd0, er}, 32'd1);
    chk("misalign_st_rdata", rd, 32'd0);
    txn(1'b0, 32'h10, 32'd0, 4'h0, rd, er);
    chk("misalign_mem_kept", rd, 32'hDE22BE44);
    chk("aligned_ld_err", {31'd0, er}, 32'd0);
    txn(1'b0, 32'h400, 32'd0, 4'h0, rd, er);
    chk("oob_ld_err", {31'd0, er}, 32'd1);
    chk("oob_ld_rdata", rd, 32'd0);
`else
    txn(1'b0, 32'h400, 32'd0, 4'h0, rd, er);
    chk("wrap_ld_rdata", rd, 32'hA5A5A5A5);
    chk("wrap_ld_err", {31'd0, er}, 32'd0);
    txn(1'b0, 32'h12, 32'd0, 4'h0, rd, er);
    chk("lowbits_ignored", rd, 32'hDE22BE44);
`endif

    // Store with no byte enables leaves the word untouched
    txn(1'b1, 32'h0, 32'hFFFFFFFF, 4'h0, rd, er);
    chk("be0_rdata", rd, 32'd0);
    txn(1'b0, 32'h0, 32'd0, 4'h0, rd, er);
    chk("be0_unchanged", rd, 32'hA5A5A5A5);

    // Zero wait states: back-to-back loads with req_valid held high
    zwrite(32'h4, 32'h0BADF00D);
    zwrite(32'h8, 32'h600DCAFE);
    z_req_we = 1'b0; z_req_addr = 32'h4; z_req_valid = 1'b1;
    @(negedge clk);
    chk("z_accept0_ready", {31'd0, z_req_ready}, 32'd1);
    chk("z_accept0_valid", {31'd0, z_rsp_valid}, 32'd0);
    @(posedge clk); #1 z_req_addr = 32'h8;
    @(negedge clk);
    chk("z_rsp0_valid", {31'd0, z_rsp_valid}, 32'd1);
    chk("z_rsp0_ready", {31'd0, z_req_ready}, 32'd0);
    chk("z_rsp0_rdata", z_rsp_rdata, 32'h0BADF00D);
    @(posedge clk); #1;
    @(negedge clk);
    chk("z_accept1_ready", {31'd0, z_req_ready}, 32'd1);
    chk("z_accept1_valid", {31'd0, z_rsp_valid}, 32'd0);
    @(posedge clk); #1 z_req_valid = 1'b0;
    @(negedge clk);
    chk("z_rsp1_valid", {31'd0, z_rsp_valid}, 32'd1);
    chk("z_rsp1_rdata", z_rsp_rdata, 32'h600DCAFE);
    chk("z_rsp1_err", {31'd0, z_rsp_err}, 32'd0);
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
